// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster scan generator for the sprite side of the VGA pipeline.
// Produces the pixel tick, the x/y raster counters, the sync and data-enable
// levels, the line/frame strobes and a one-cycle sprite arm request
// (spr_start) issued at the start of horizontal blank on the line before the
// latched sprite row. Every output is registered: all outputs are computed
// from the next counter values, so the counters, levels and strobes change on
// the same clk edge.
module vga_scan_gen #(
    parameter int CLK_DIV  = 1,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] spr_y,
    output logic       pix_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       line_start,
    output logic       frame_start,
    output logic       spr_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT_C   = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT_C   = 10'(V_ACTIVE);
    localparam logic [9:0]       HS_BEG    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]       VS_BEG    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]       SPR_OFF   = 10'h3FF;

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_nxt_s;
    logic             adv_s;
    logic [9:0]       x_nxt_s;
    logic [9:0]       y_nxt_s;
    logic [9:0]       spr_y_q_r;
    logic [9:0]       spr_line_s;
    logic             spr_en_s;

    // Next-state of the divider and raster counters, plus the sprite arm line.
    always_comb begin
        adv_s      = (div_r == DIV_MAX);
        div_nxt_s  = div_r;
        x_nxt_s    = pixel_x;
        y_nxt_s    = pixel_y;
        spr_line_s = V_LAST;
        spr_en_s   = (spr_y_q_r < V_ACT_C);

        if (adv_s) begin
            div_nxt_s = {DIV_W{1'b0}};
        end else begin
            div_nxt_s = div_r + DIV_ONE;
        end

        if (adv_s) begin
            if (pixel_x == H_LAST) begin
                x_nxt_s = 10'd0;
                if (pixel_y == V_LAST) begin
                    y_nxt_s = 10'd0;
                end else begin
                    y_nxt_s = pixel_y + 10'd1;
                end
            end else begin
                x_nxt_s = pixel_x + 10'd1;
                y_nxt_s = pixel_y;
            end
        end else begin
            x_nxt_s = pixel_x;
            y_nxt_s = pixel_y;
        end

        // Sprite row 0 is armed on the last line of the preceding frame.
        if (spr_y_q_r == 10'd0) begin
            spr_line_s = V_LAST;
        end else begin
            spr_line_s = spr_y_q_r - 10'd1;
        end
    end

    // Register counters, levels, strobes and the per-frame sprite row latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r       <= {DIV_W{1'b0}};
            pix_tick    <= 1'b0;
            pixel_x     <= H_LAST;
            pixel_y     <= V_LAST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            spr_start   <= 1'b0;
            spr_y_q_r   <= SPR_OFF;
        end else begin
            div_r       <= div_nxt_s;
            pix_tick    <= (div_nxt_s == DIV_MAX);
            pixel_x     <= x_nxt_s;
            pixel_y     <= y_nxt_s;
            hsync       <= !((x_nxt_s >= HS_BEG) && (x_nxt_s < HS_END));
            vsync       <= !((y_nxt_s >= VS_BEG) && (y_nxt_s < VS_END));
            de          <= (x_nxt_s < H_ACT_C) && (y_nxt_s < V_ACT_C);
            line_start  <= adv_s && (x_nxt_s == 10'd0);
            frame_start <= adv_s && (x_nxt_s == 10'd0) && (y_nxt_s == 10'd0);
            spr_start   <= adv_s && spr_en_s && (x_nxt_s == H_ACT_C) &&
                           (y_nxt_s == spr_line_s);
            // Capture during the frame_start cycle so a same-cycle change wins.
            if (frame_start) begin
                spr_y_q_r <= spr_y;
            end else begin
                spr_y_q_r <= spr_y_q_r;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Testbench for vga_scan_gen: two instances with a reduced raster (24x15),
// one at CLK_DIV=1 and one at CLK_DIV=3, compared every cycle against a
// closed-form reference computed from the number of clk edges since reset.
module tb_vga_scan_gen;

    localparam int HACT = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VACT = 10, VFP = 1, VSW = 2, VBP = 2;
    localparam int HT = HACT + HFP + HSW + HBP;
    localparam int VT = VACT + VFP + VSW + VBP;
    localparam int NPIX = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] spr_y = 10'd0;

    logic       pt1, hs1, vs1, de1, ls1, fs1, ss1;
    logic [9:0] px1, py1;
    logic       pt3, hs3, vs3, de3, ls3, fs3, ss3;
    logic [9:0] px3, py3;

    int checks = 0;
    int failures = 0;

    // Reference state: edges since reset release and the latched sprite row.
    int         e1 = 0, e3 = 0;
    logic [9:0] q1 = 10'h3FF, q3 = 10'h3FF;

    always #5 clk = ~clk;

    vga_scan_gen #(.CLK_DIV(1), .H_ACTIVE(HACT), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                   .V_ACTIVE(VACT), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)) u_dut1 (
        .clk(clk), .rst(rst), .spr_y(spr_y), .pix_tick(pt1), .pixel_x(px1), .pixel_y(py1),
        .hsync(hs1), .vsync(vs1), .de(de1), .line_start(ls1), .frame_start(fs1),
        .spr_start(ss1));

    vga_scan_gen #(.CLK_DIV(3), .H_ACTIVE(HACT), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                   .V_ACTIVE(VACT), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)) u_dut3 (
        .clk(clk), .rst(rst), .spr_y(spr_y), .pix_tick(pt3), .pixel_x(px3), .pixel_y(py3),
        .hsync(hs3), .vsync(vs3), .de(de3), .line_start(ls3), .frame_start(fs3),
        .spr_start(ss3));

    // Expected {pix_tick, x, y, hsync, vsync, de, line_start, frame_start, spr_start}
    // after e edges since reset, for divider d and latched sprite row q.
    function automatic logic [26:0] exp_vec(input int e, input int d, input logic [9:0] q);
        int a, idx, x, y, l;
        logic adv, pt, ls, fs, ss, dv, hs, vs;
        a   = e / d;
        idx = (a + NPIX - 1) % NPIX;
        x   = idx % HT;
        y   = idx / HT;
        adv = (e > 0) && (e % d == 0);
        pt  = (e > 0) && ((e + 1) % d == 0);
        ls  = adv && (x == 0);
        fs  = adv && (idx == 0);
        l   = (q == 10'd0) ? VT - 1 : int'(q) - 1;
        ss  = adv && (x == HACT) && (int'(q) < VACT) && (y == l);
        dv  = (x < HACT) && (y < VACT);
        hs  = !((x >= HACT + HFP) && (x < HACT + HFP + HSW));
        vs  = !((y >= VACT + VFP) && (y < VACT + VFP + VSW));
        return {pt, 10'(x), 10'(y), hs, vs, dv, ls, fs, ss};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, obs, expv);
        end
    endtask

    task automatic cmp_dut(input string p, input logic [26:0] o, input logic [26:0] x);
        check({p, ".pix_tick"},    32'(o[26]),    32'(x[26]));
        check({p, ".pixel_x"},     32'(o[25:16]), 32'(x[25:16]));
        check({p, ".pixel_y"},     32'(o[15:6]),  32'(x[15:6]));
        check({p, ".hsync"},       32'(o[5]),     32'(x[5]));
        check({p, ".vsync"},       32'(o[4]),     32'(x[4]));
        check({p, ".de"},          32'(o[3]),     32'(x[3]));
        check({p, ".line_start"},  32'(o[2]),     32'(x[2]));
        check({p, ".frame_start"}, 32'(o[1]),     32'(x[1]));
        check({p, ".spr_start"},   32'(o[0]),     32'(x[0]));
    endtask

    // Advance the reference on every clk edge; latch spr_y when frame_start is showing.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e1 <= 0; e3 <= 0; q1 <= 10'h3FF; q3 <= 10'h3FF;
        end else begin
            e1 <= e1 + 1;
            e3 <= e3 + 1;
            if (exp_vec(e1, 1, q1)[1]) q1 <= spr_y;
            if (exp_vec(e3, 3, q3)[1]) q3 <= spr_y;
        end
    end

    // Compare both instances against the reference away from the active edge.
    always @(negedge clk) begin
        cmp_dut("d1", {pt1, px1, py1, hs1, vs1, de1, ls1, fs1, ss1}, exp_vec(e1, 1, q1));
        cmp_dut("d3", {pt3, px3, py3, hs3, vs3, de3, ls3, fs3, ss3}, exp_vec(e3, 3, q3));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_now();
        check("rst.pixel_x", 32'(px1), 32'(HT - 1));
        check("rst.pixel_y", 32'(py1), 32'(VT - 1));
        check("rst.levels",  32'({hs1, vs1, de1, pt1}), 32'(4'b1100));
        check("rst.strobes", 32'({ls1, fs1, ss1, ls3, fs3, ss3}), 32'(6'd0));
        check("rst.pixel_x3", 32'(px3), 32'(HT - 1));
    endtask

    initial begin
        int n;
        int guard;
        rst = 1'b1;
        spr_y = 10'd4;
        repeat (3) step();
        check_reset_now();
        rst = 1'b0;
        step();
        // CLK_DIV=1: one clk after release the raster sits at (0,0) with both strobes.
        check("first.frame_start", 32'(fs1), 32'd1);
        check("first.line_start",  32'(ls1), 32'd1);
        check("first.de",          32'(de1), 32'd1);

        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1500, 2500);
            for (int c = 0; c < n; c++) begin
                step();
                if ($urandom_range(0, 199) == 0) begin
                    if ($urandom_range(0, 3) == 0) spr_y = 10'($urandom_range(0, 1023));
                    else spr_y = 10'($urandom_range(0, VT - 1));
                end
            end
            if (it % 2 == 1) begin
                #($urandom_range(0, 6));
                rst = 1'b1;
                #1;
                check_reset_now();
                step();
                rst = 1'b0;
            end
        end

        // Assert reset in the cycle before an expected sprite arm pulse.
        spr_y = 10'd5;
        guard = 0;
        while (!exp_vec(e1 + 1, 1, q1)[0] && guard < 2000) begin
            step();
            guard++;
        end
        check("arm_wait", 32'(guard < 2000), 32'd1);
        rst = 1'b1;
        #1;
        check("arm_rst.spr_start", 32'(ss1), 32'd0);
        step();
        check("arm_rst.spr_start_held", 32'(ss1), 32'd0);
        rst = 1'b0;
        repeat (3 * NPIX) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Raster scan generator that drives the sprite-drawing side of the VGA pipeline. It produces the pixel tick, counters (`pixel_x`, `pixel_y`), sync and data-enable signals, and per-frame / per-line strobes. It also issues the one-cycle `spr_start` request that tells a sprite drawer to arm for the coming sprite row. Sits between the system clock domain and every sprite drawer and colour mixer; all consumers run on the same `clk`.

## Interface
- `CLK_DIV`, 1: `clk` cycles per pixel; 1 means `clk` is the pixel clock.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch (pixels).
- `H_SYNC`, 96: horizontal sync width (pixels).
- `H_BP`, 48: horizontal back porch (pixels).
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch (lines).
- `V_SYNC`, 2: vertical sync width (lines).
- `V_BP`, 33: vertical back porch (lines).
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, asynchronous, active-high.
- `spr_y` in 10: top sprite row; sampled at frame start.
- `pix_tick` out 1: one-`clk` pulse per pixel period.
- `pixel_x` out 10: horizontal counter, 0..H_TOTAL-1.
- `pixel_y` out 10: vertical counter, 0..V_TOTAL-1.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `de` out 1: high when the pixel is in the visible area.
- `line_start` out 1: one-`clk` pulse when `pixel_x` wraps to 0.
- `frame_start` out 1: one-`clk` pulse when (`pixel_x`, `pixel_y`) becomes (0,0).
- `spr_start` out 1: one-`clk` sprite arm pulse.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, which is 800 at the defaults. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, which is 525 at the defaults.
- Divider counter `div` counts 0..CLK_DIV-1. `pix_tick` is high in the cycle where `div`==CLK_DIV-1. With CLK_DIV=1, `pix_tick` is constantly high after reset.
- On each `pix_tick`, `pixel_x` increments. At H_TOTAL-1 it wraps to 0 and `pixel_y` increments. `pixel_y` wraps from V_TOTAL-1 to 0.
- `de` = (`pixel_x` < H_ACTIVE) && (`pixel_y` < V_ACTIVE).
- `hsync` is low when H_ACTIVE+H_FP <= `pixel_x` < H_ACTIVE+H_FP+H_SYNC, which is 656..751 at the defaults.
- `vsync` is low when V_ACTIVE+V_FP <= `pixel_y` < V_ACTIVE+V_FP+V_SYNC, which is 490..491 at the defaults.
- Sprite row latch `spr_y_q`:
  - Loaded from `spr_y` in the cycle that `frame_start` is asserted.
  - Reset value is 10'h3FF, which disables `spr_start`.
- `spr_start` fires when the counters take the value `pixel_x`==H_ACTIVE (start of horizontal blank) on line L:
  - L = `spr_y_q`-1 when `spr_y_q` >= 1.
  - L = V_TOTAL-1 when `spr_y_q`==0. This is the last line of the previous frame and uses the `spr_y_q` latched for the current frame.
  - There is no pulse when `spr_y_q` >= V_ACTIVE.
- The `spr_start` timing leaves the downstream drawer the full blank interval to pass through its start and await-position phases before `pixel_x` returns to 0.
- Exactly one `spr_start` pulse is issued per frame while `spr_y_q` < V_ACTIVE.

## Timing
- All outputs are registered. `pixel_x`, `pixel_y`, `hsync`, `vsync`, `de` and the strobes change in the same `clk` edge, with no skew between them.
- `line_start`, `frame_start` and `spr_start` are exactly one `clk` wide, regardless of CLK_DIV. They are asserted in the first cycle the counters hold the new value.
- The counters and the level outputs (`hsync`, `vsync`, `de`) hold their values for CLK_DIV cycles.
- Reset values:
  - `div`=0.
  - `pixel_x`=H_TOTAL-1, `pixel_y`=V_TOTAL-1.
  - `hsync`=1, `vsync`=1, `de`=0.
  - `pix_tick`=0, `line_start`=0, `frame_start`=0, `spr_start`=0.
- First pixel after reset: the first `pix_tick` after `rst` deasserts wraps the counters to (0,0) and raises `frame_start` and `line_start` one `clk` later. The first frame is therefore complete.
- `rst` asserted mid-frame returns every output to its reset value immediately (asynchronous). No pending strobe survives reset.
- A `spr_y` change mid-frame has no effect until the next `frame_start`.
- If `spr_y` changes in the same cycle as `frame_start`, the new value is captured.

## Test plan
- Reset: assert `rst` mid-line.
  - Immediately: `pixel_x`=799, `pixel_y`=524, `hsync`=1, `vsync`=1, `de`=0, all strobes 0.
  - After release with CLK_DIV=1: `frame_start` and `line_start` pulse one `clk` later, with `pixel_x`=0, `pixel_y`=0, `de`=1.
- Sync geometry, defaults, CLK_DIV=1:
  - `hsync` is low for exactly 96 `clk`, starting at `pixel_x`=656.
  - `vsync` is low for exactly 1600 `clk` on lines 490-491.
  - `de` is high for 640 `clk` per visible line and 0 on lines 480-524.
- Frame period: with CLK_DIV=4, consecutive `frame_start` pulses are 800*525*4 = 1,680,000 `clk` apart. `pix_tick` fires every 4th `clk`, and `line_start` fires 525 times per frame.
- Sprite arm: `spr_y`=100 → one `spr_start` per frame, coincident with `pixel_x`=640, `pixel_y`=99. `spr_y`=0 → `spr_start` at `pixel_x`=640, `pixel_y`=524.
- Disable and update:
  - `spr_y`=480 → no `spr_start` for a full frame.
  - Change `spr_y` from 100 to 200 at line 50 → the current frame still pulses at line 99; the next frame pulses at line 199.
- Reset during sprite arm: assert `rst` in the cycle before the expected `spr_start` → no pulse. After release, `spr_start` stays 0 until `frame_start` latches a valid `spr_y`.
